// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection, forwarding selects, the
// multiply/divide hold sequencer and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  input  logic [4:0]       Rs_E,
  input  logic [4:0]       Rt_E,
  input  logic [4:0]       WriteReg_E,
  input  logic [4:0]       WriteReg_M,
  input  logic [4:0]       WriteReg_W,
  input  logic             RegWrite_E,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             MemtoReg_E,
  input  logic             MemtoReg_M,
  input  logic             Branch_D,
  input  logic             PCSrc_D,
  input  logic             md_start_E,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Bubble_M,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             ForwardA_D,
  output logic             ForwardB_D,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // BUSY is entered one cycle after the start cycle and DONE takes the
  // final cycle, so the BUSY countdown spans MD_LATENCY-2 cycles.
  localparam logic [3:0] CNT_LOAD = 4'(MD_LATENCY - 2);

  logic [1:0] state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic lwstall, brstall, mdstall;

  // A writer hits a reader when it writes a non-zero register equal to the source
  function automatic logic hit(input logic we, input logic [4:0] dst,
                               input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  // Hazard terms and all combinational outputs; everything held at 0 in reset
  always_comb begin
    lwstall    = 1'b0;
    brstall    = 1'b0;
    mdstall    = 1'b0;
    Stall_F    = 1'b0;
    Stall_D    = 1'b0;
    Stall_E    = 1'b0;
    Flush_D    = 1'b0;
    Flush_E    = 1'b0;
    Bubble_M   = 1'b0;
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    ForwardA_D = 1'b0;
    ForwardB_D = 1'b0;
    md_done    = 1'b0;
    if (!reset) begin
      if (hit(RegWrite_M, WriteReg_M, Rs_E))      ForwardA_E = 2'b10;
      else if (hit(RegWrite_W, WriteReg_W, Rs_E)) ForwardA_E = 2'b01;
      if (hit(RegWrite_M, WriteReg_M, Rt_E))      ForwardB_E = 2'b10;
      else if (hit(RegWrite_W, WriteReg_W, Rt_E)) ForwardB_E = 2'b01;

      ForwardA_D = hit(RegWrite_M, WriteReg_M, Rs_D);
      ForwardB_D = hit(RegWrite_M, WriteReg_M, Rt_D);

      lwstall = MemtoReg_E &&
                (hit(RegWrite_E, WriteReg_E, Rs_D) || hit(RegWrite_E, WriteReg_E, Rt_D));
      brstall = Branch_D &&
                (hit(RegWrite_E, WriteReg_E, Rs_D) || hit(RegWrite_E, WriteReg_E, Rt_D) ||
                 hit(MemtoReg_M, WriteReg_M, Rs_D) || hit(MemtoReg_M, WriteReg_M, Rt_D));
      mdstall = ((state == IDLE) && md_start_E) || (state == BUSY);

      Stall_F  = lwstall || brstall || mdstall;
      Stall_D  = Stall_F;
      Stall_E  = mdstall;
      Bubble_M = mdstall;
      // The held multiply/divide sits in ID/EX and must not be flushed
      Flush_E  = (lwstall || brstall) && !mdstall;
      Flush_D  = PCSrc_D && !Stall_D;
      md_done  = (state == DONE);
    end
  end

  // Multiply/divide sequencer next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (md_start_E) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == 4'd1) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating count of cycles with the front end stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (Stall_F && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic        RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
  logic        Branch_D, PCSrc_D, md_start_E;
  logic        Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Bubble_M;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        ForwardA_D, ForwardB_D, md_done;
  logic [15:0] stall_cycles;

  typedef struct {
    string       tag;
    logic        sf, se, fd, fe, fad, fbd, done;
    logic [1:0]  fae, fbe;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
    .Branch_D(Branch_D), .PCSrc_D(PCSrc_D), .md_start_E(md_start_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Bubble_M(Bubble_M),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .md_done(md_done), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    Rs_D = '0; Rt_D = '0; Rs_E = '0; Rt_E = '0;
    WriteReg_E = '0; WriteReg_M = '0; WriteReg_W = '0;
    RegWrite_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    MemtoReg_E = 1'b0; MemtoReg_M = 1'b0;
    Branch_D = 1'b0; PCSrc_D = 1'b0; md_start_E = 1'b0;
  endtask

  // Queue the expectation for the inputs just driven, then compare at the
  // falling edge and return just after the next rising edge.
  task automatic step(input string tag, input logic sf, input logic se,
                      input logic fd, input logic fe, input logic [1:0] fae,
                      input logic [1:0] fbe, input logic fad, input logic fbd,
                      input logic done, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.sf = sf; e.se = se; e.fd = fd; e.fe = fe;
    e.fae = fae; e.fbe = fbe; e.fad = fad; e.fbd = fbd; e.done = done; e.cnt = cnt;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".Stall_F"},      32'(Stall_F),      32'(e.sf));
      check({e.tag, ".Stall_D"},      32'(Stall_D),      32'(e.sf));
      check({e.tag, ".Stall_E"},      32'(Stall_E),      32'(e.se));
      check({e.tag, ".Bubble_M"},     32'(Bubble_M),     32'(e.se));
      check({e.tag, ".Flush_D"},      32'(Flush_D),      32'(e.fd));
      check({e.tag, ".Flush_E"},      32'(Flush_E),      32'(e.fe));
      check({e.tag, ".ForwardA_E"},   32'(ForwardA_E),   32'(e.fae));
      check({e.tag, ".ForwardB_E"},   32'(ForwardB_E),   32'(e.fbe));
      check({e.tag, ".ForwardA_D"},   32'(ForwardA_D),   32'(e.fad));
      check({e.tag, ".ForwardB_D"},   32'(ForwardB_D),   32'(e.fbd));
      check({e.tag, ".md_done"},      32'(md_done),      32'(e.done));
      check({e.tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.cnt));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    @(posedge clk);
    #1;

    // Reset forces outputs low even with hazards present
    md_start_E = 1'b1; RegWrite_M = 1'b1; WriteReg_M = 5'd5; Rs_E = 5'd5;
    Rs_D = 5'd5; Branch_D = 1'b1; PCSrc_D = 1'b1;
    step("rst_hold", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd0);

    reset = 1'b0;
    clr(); RegWrite_M = 1'b1; WriteReg_M = 5'd5; RegWrite_W = 1'b1; WriteReg_W = 5'd5; Rs_E = 5'd5;
    step("fwd_m_prio", 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 16'd0);

    clr(); RegWrite_M = 1'b1; RegWrite_W = 1'b1;
    step("fwd_r0", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd0);

    clr(); RegWrite_M = 1'b1; WriteReg_M = 5'd3; RegWrite_W = 1'b1; WriteReg_W = 5'd7;
    Rs_E = 5'd7; Rt_E = 5'd3; Rt_D = 5'd3;
    step("fwd_w", 0, 0, 0, 0, 2'b01, 2'b10, 0, 1, 0, 16'd0);

    clr(); MemtoReg_E = 1'b1; RegWrite_E = 1'b1; WriteReg_E = 5'd8; Rt_D = 5'd8;
    step("lw", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 16'd0);
    clr();
    step("lw_after", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd1);

    clr(); Branch_D = 1'b1; Rs_D = 5'd9; RegWrite_E = 1'b1; WriteReg_E = 5'd9; PCSrc_D = 1'b1;
    step("br_e", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 16'd1);
    clr(); Branch_D = 1'b1; Rs_D = 5'd9; RegWrite_M = 1'b1; WriteReg_M = 5'd9; PCSrc_D = 1'b1;
    step("br_m", 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 16'd2);
    clr(); Branch_D = 1'b1; Rt_D = 5'd4; MemtoReg_M = 1'b1; RegWrite_M = 1'b1; WriteReg_M = 5'd4;
    step("br_ld_m", 1, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0, 16'd2);

    // Multiply/divide, latency 4, with a load-use and taken branch overlapping t1
    clr(); md_start_E = 1'b1;
    step("md_t0", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd3);
    MemtoReg_E = 1'b1; RegWrite_E = 1'b1; WriteReg_E = 5'd8; Rt_D = 5'd8; PCSrc_D = 1'b1;
    step("md_t1_mix", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd4);
    clr(); md_start_E = 1'b1;
    step("md_t2", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd5);
    step("md_t3", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 16'd6);
    step("md2_t0", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd6);
    step("md2_t1", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd7);
    step("md2_t2", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd8);
    step("md2_t3", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 16'd9);
    clr();
    step("md_idle", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd9);

    // Reset while BUSY
    md_start_E = 1'b1;
    step("md3_t0", 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd9);
    reset = 1'b1;
    step("rst_busy", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd0);
    reset = 1'b0;
    clr();
    step("rst_rel", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd0);
    step("no_done1", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd0);
    step("no_done2", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'd0);

    // Saturation of the stall counter
    MemtoReg_E = 1'b1; RegWrite_E = 1'b1; WriteReg_E = 5'd8; Rt_D = 5'd8;
    repeat (65534) @(posedge clk);
    #1;
    step("sat_pre", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 16'hFFFE);
    step("sat_max", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 16'hFFFF);
    clr();
    step("sat_hold", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives the stall, flush and bubble enables of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Generates the forwarding selects for the EX and D (branch-compare) stages.
- Runs a state machine that holds the pipeline while a multi-cycle multiply/divide occupies EX. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MD_LATENCY, 4, total cycles a multiply/divide instruction occupies EX; legal range 3..16.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
Rs_D  in  5  source register 1 of instruction in D
Rt_D  in  5  source register 2 of instruction in D
Rs_E  in  5  source register 1 of instruction in E
Rt_E  in  5  source register 2 of instruction in E
WriteReg_E  in  5  destination register in E
WriteReg_M  in  5  destination register in M
WriteReg_W  in  5  destination register in W
RegWrite_E  in  1  E instruction writes the register file
RegWrite_M  in  1  M instruction writes the register file
RegWrite_W  in  1  W instruction writes the register file
MemtoReg_E  in  1  E instruction is a load
MemtoReg_M  in  1  M instruction is a load
Branch_D  in  1  D instruction is a branch compared in D
PCSrc_D  in  1  branch taken, resolved in D
md_start_E  in  1  E instruction is a multi-cycle multiply/divide
Stall_F  out  1  hold PC
Stall_D  out  1  hold IF/ID
Stall_E  out  1  hold ID/EX
Flush_D  out  1  clear IF/ID
Flush_E  out  1  clear ID/EX (bubble)
Bubble_M  out  1  EX/MEM loads all-zero control (MEM=0, WB=0)
ForwardA_E  out  2  00 regfile, 10 from M ALUOut, 01 from W result
ForwardB_E  out  2  same encoding, for Rt_E
ForwardA_D  out  1  Rs_D compare operand taken from M ALUOut
ForwardB_D  out  1  Rt_D compare operand taken from M ALUOut
md_done  out  1  final EX cycle of the multiply/divide; result valid
stall_cycles  out  CNT_W  saturating count of cycles with Stall_F=1

Behaviour:
- Reset (asynchronous): state=IDLE, cnt=0, stall_cycles=0. While reset is high, every combinational output is forced to 0.
- EX forwarding (combinational, no latency):
  - ForwardA_E=10 if RegWrite_M && WriteReg_M!=0 && WriteReg_M==Rs_E.
  - Otherwise ForwardA_E=01 if RegWrite_W && WriteReg_W!=0 && WriteReg_W==Rs_E.
  - Otherwise 00. ForwardB_E uses the same rules with Rt_E.
  - M has priority over W. Register 0 is never forwarded.
- D forwarding: ForwardA_D = RegWrite_M && WriteReg_M!=0 && WriteReg_M==Rs_D. ForwardB_D is the same with Rt_D.
- lwstall = MemtoReg_E && RegWrite_E && WriteReg_E!=0 && (WriteReg_E==Rs_D || WriteReg_E==Rt_D).
- brstall = Branch_D && ((RegWrite_E && WriteReg_E!=0 && WriteReg_E matches Rs_D or Rt_D) || (MemtoReg_M && WriteReg_M!=0 && WriteReg_M matches Rs_D or Rt_D)).
- mdstall = (state==IDLE && md_start_E) || state==BUSY.
- Output equations:
  - Stall_F = Stall_D = lwstall || brstall || mdstall.
  - Stall_E = mdstall.
  - Bubble_M = mdstall.
  - Flush_E = (lwstall || brstall) && !mdstall. The held multiply/divide must never be flushed.
  - Flush_D = PCSrc_D && !Stall_D.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if md_start_E, go to BUSY and load cnt=MD_LATENCY-2.
  - BUSY: if cnt==1, go to DONE; else cnt decrements.
  - DONE: md_done=1, no md stall; always go to IDLE. md_start_E in DONE belongs to the finishing instruction and is ignored.
  - Net effect: stall on cycles t0..t0+MD_LATENCY-2, md_done at t0+MD_LATENCY-1, instruction enters EX/MEM at the next edge.
- Back-to-back multiply/divide: a new md_start_E in the cycle after DONE (state IDLE) starts a fresh sequence.
- stall_cycles increments on each edge where Stall_F=1. It saturates at all-ones and does not wrap.
- A reset during BUSY returns to IDLE immediately; no md_done pulse is produced.

Test Plan:
- EX forwarding: RegWrite_M=1, WriteReg_M=5, RegWrite_W=1, WriteReg_W=5, Rs_E=5 -> ForwardA_E=10. Same with WriteReg_M=0 and Rs_E=0 -> ForwardA_E=00.
- Load-use: MemtoReg_E=1, RegWrite_E=1, WriteReg_E=8, Rt_D=8 -> Stall_F=Stall_D=Flush_E=1 for exactly one cycle; stall_cycles goes 0 -> 1.
- Branch hazard: Branch_D=1, Rs_D=9, RegWrite_E=1, WriteReg_E=9 -> stall asserted. Next cycle with M-stage ALU producer of r9 -> no stall, ForwardA_D=1.
- Multiply/divide with MD_LATENCY=4: md_start_E=1 at t0 -> Stall_E=Bubble_M=1 at t0, t1, t2, Flush_E=0 throughout; md_done=1 at t3 only; state IDLE at t4.
- Simultaneous events: md stall active with lwstall and PCSrc_D=1 -> Flush_E=0, Flush_D=0, Stall_D=1.
- Reset at t1 of a multiply/divide sequence -> all outputs 0 immediately, state IDLE, stall_cycles=0, no md_done afterwards. Saturation: force 65535 stall cycles, then one more -> stall_cycles stays 0xFFFF.
